// File: rtl/shift_pkg.sv
// Shared types for the pipelined right shifter / power-of-two divider.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSR = 2'd0,
    SHIFT_ASR = 2'd1,
    SHIFT_DIV = 2'd2,
    SHIFT_RSV = 2'd3
  } shift_mode_t;

endpackage

// File: rtl/pipelined_shift_right_div_pow2_if.sv
// Operand/result bus of the pipelined shifter, one valid/ready channel per side.
interface pipelined_shift_right_div_pow2_if #(
  parameter int N = 8
);
  import shift_pkg::*;

  localparam int SW = $clog2(N);

  // Handshake: a beat transfers on a rising clk edge where valid and ready are both 1.
  // valid must not depend on ready; payload is held stable while valid is high and ready low.
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  shift_mode_t   in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/shift_pipe_stage.sv
// One registered barrel stage: shifts right by 2**(K-1) with sign fill when shamt bit K-1 is set.
module shift_pipe_stage #(
  parameter int N  = 8,
  parameter int SW = 3,
  parameter int K  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          valid_i,
  input  logic          sign_i,
  input  logic          sat_i,
  input  logic [SW-1:0] shamt_i,
  input  logic [N-1:0]  data_i,
  output logic          valid_o,
  output logic          sign_o,
  output logic          sat_o,
  output logic [SW-1:0] shamt_o,
  output logic [N-1:0]  data_o
);

  localparam int DIST = 1 << (K - 1);
  localparam int FILL = (DIST < N) ? DIST : N;

  logic [N-1:0]  shifted;
  logic          valid_q, valid_d;
  logic          sign_q, sign_d;
  logic          sat_q, sat_d;
  logic [SW-1:0] shamt_q, shamt_d;
  logic [N-1:0]  data_q, data_d;

  generate
    if (FILL >= N) begin : g_full_fill
      assign shifted = {N{sign_i}};
    end else begin : g_part_fill
      assign shifted = {{FILL{sign_i}}, data_i[N-1:FILL]};
    end
  endgenerate

  // A saturated item already holds its final value, so it passes untouched.
  always_comb begin
    valid_d = valid_i;
    sign_d  = sign_i;
    sat_d   = sat_i;
    shamt_d = shamt_i;
    data_d  = (shamt_i[K-1] && !sat_i) ? shifted : data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sign_q  <= 1'b0;
      sat_q   <= 1'b0;
      shamt_q <= '0;
      data_q  <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      sign_q  <= sign_d;
      sat_q   <= sat_d;
      shamt_q <= shamt_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign sign_o  = sign_q;
  assign sat_o   = sat_q;
  assign shamt_o = shamt_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipelined_shift_right_div_pow2.sv
// Pipelined right shifter: logical, arithmetic (floor) and signed divide by 2**shamt (toward zero).
module pipelined_shift_right_div_pow2 #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  pipelined_shift_right_div_pow2_if.slave bus
);
  import shift_pkg::*;

  localparam int SW     = $clog2(N);
  localparam int STAGES = SW;
  localparam logic [SW:0] N_W = (SW + 1)'(N);

  logic          en;
  logic          arith;
  logic          sat0;
  logic [N-1:0]  bias;
  logic [N-1:0]  op0;

  logic          valid0_q, valid0_d;
  logic          sign0_q, sign0_d;
  logic          sat0_q, sat0_d;
  logic [SW-1:0] shamt0_q, shamt0_d;
  logic [N-1:0]  data0_q, data0_d;

  logic          valid_p [STAGES+1];
  logic          sign_p  [STAGES+1];
  logic          sat_p   [STAGES+1];
  logic [SW-1:0] shamt_p [STAGES+1];
  logic [N-1:0]  data_p  [STAGES+1];
  logic          unused_tail;

  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // Stage 0: DIV pre-biases negatives by 2**s-1 so the floor shift truncates toward zero.
  always_comb begin
    arith = (bus.in_mode != SHIFT_LSR);
    sat0  = ({1'b0, bus.in_shamt} >= N_W);
    bias  = ~({N{1'b1}} << bus.in_shamt);
    if (sat0)
      op0 = {N{(bus.in_mode == SHIFT_ASR || bus.in_mode == SHIFT_RSV) && bus.in_data[N-1]}};
    else if (bus.in_mode == SHIFT_DIV && bus.in_data[N-1])
      op0 = bus.in_data + bias;
    else
      op0 = bus.in_data;
  end

  // Fill follows the biased operand: a small negative dividend turns non-negative and must shift to 0.
  always_comb begin
    valid0_d = bus.in_valid;
    sign0_d  = arith && op0[N-1];
    sat0_d   = sat0;
    shamt0_d = bus.in_shamt;
    data0_d  = op0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid0_q <= 1'b0;
      sign0_q  <= 1'b0;
      sat0_q   <= 1'b0;
      shamt0_q <= '0;
      data0_q  <= '0;
    end else if (en) begin
      valid0_q <= valid0_d;
      sign0_q  <= sign0_d;
      sat0_q   <= sat0_d;
      shamt0_q <= shamt0_d;
      data0_q  <= data0_d;
    end
  end

  assign valid_p[0] = valid0_q;
  assign sign_p[0]  = sign0_q;
  assign sat_p[0]   = sat0_q;
  assign shamt_p[0] = shamt0_q;
  assign data_p[0]  = data0_q;

  generate
    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
      shift_pipe_stage #(.N(N), .SW(SW), .K(k)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .valid_i (valid_p[k-1]),
        .sign_i  (sign_p[k-1]),
        .sat_i   (sat_p[k-1]),
        .shamt_i (shamt_p[k-1]),
        .data_i  (data_p[k-1]),
        .valid_o (valid_p[k]),
        .sign_o  (sign_p[k]),
        .sat_o   (sat_p[k]),
        .shamt_o (shamt_p[k]),
        .data_o  (data_p[k])
      );
    end
  endgenerate

  // Masking with rst keeps a downstream handshake from completing in the reset cycle.
  assign bus.out_valid = valid_p[STAGES] && !rst;
  assign bus.out_data  = data_p[STAGES];
  assign unused_tail   = ^{sign_p[STAGES], sat_p[STAGES], shamt_p[STAGES]};

endmodule

// File: tb/tb_pipelined_shift_right_div_pow2.sv
// Scoreboard bench for the pipelined shifter at N=8: directed, stall, reset and exhaustive sweep.
module tb_pipelined_shift_right_div_pow2;
  import shift_pkg::*;

  localparam int N      = 8;
  localparam int SW     = 3;
  localparam int STAGES = SW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pipelined_shift_right_div_pow2_if #(.N(N)) bus ();

  pipelined_shift_right_div_pow2 #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] exp_q[$];
  int acc_q[$];
  int cyc        = 0;
  int acc_cnt    = 0;
  int pop_cnt    = 0;
  int prev_pop   = 0;
  int tput_base  = 0;
  int rdy_mode   = 0;
  bit lat_chk    = 1'b0;
  bit tput_chk   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain >>, >>> on a signed int, and C-style signed division.
  function automatic logic [N-1:0] model(input logic [N-1:0] a, input int s, input int m);
    int ai;
    logic [31:0] r;
    ai = int'($signed(a));
    case (m)
      0:       r = 32'(a) >> s;
      2:       r = ai / (1 << s);
      default: r = ai >>> s;
    endcase
    return r[N-1:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] e;
    int a;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end else if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_spurious", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        pop_cnt++;
        check_eq("data", bus.out_data, e);
        if (lat_chk) check_eq("latency", cyc - a + 1, STAGES + 1);
        if (tput_chk && (pop_cnt - tput_base) >= 2) check_eq("tput_gap", cyc - prev_pop, 1);
        prev_pop = cyc;
      end
    end
  end

  task automatic drive(input logic [N-1:0] a, input int s, input int m, input logic [N-1:0] e);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = a;
    bus.in_shamt = s[SW-1:0];
    bus.in_mode  = shift_mode_t'(m[1:0]);
    @(negedge clk);
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      check_eq("drv_timeout", n, 0);
    end else begin
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a_r, s_r, m_r;
    int base, base_acc, base_pop;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_shamt = '0;
    bus.in_mode  = SHIFT_LSR;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed values and edge cases, latency checked on each.
    lat_chk = 1'b1;
    drive(8'hED, 3, 0, 8'h1D);
    drive(8'hED, 3, 1, 8'hFD);
    drive(8'hED, 3, 2, 8'hFE);
    drive(8'h80, 7, 1, 8'hFF);
    drive(8'h80, 7, 2, 8'hFF);
    drive(8'h80, 7, 0, 8'h01);
    for (int m = 0; m < 3; m++) drive(8'h80, 0, m, 8'h80);
    drive(8'hFF, 5, 1, 8'hFF);
    drive(8'hFF, 1, 2, 8'h00);
    drive(8'hFF, 7, 2, 8'h00);
    drive(8'hFF, 4, 3, 8'hFF);
    drain();

    // Back-to-back random stream.
    tput_base = pop_cnt;
    tput_chk  = 1'b1;
    base      = pop_cnt;
    for (int i = 0; i < 20; i++) begin
      a_r = $urandom_range(0, 255);
      s_r = $urandom_range(0, 7);
      m_r = $urandom_range(0, 3);
      drive(a_r[N-1:0], s_r, m_r, model(a_r[N-1:0], s_r, m_r));
    end
    drain();
    tput_chk = 1'b0;
    check_eq("stream_count", pop_cnt - base, 20);

    // Output stall for 3 clocks with a result waiting.
    lat_chk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_r = $urandom_range(0, 255);
      s_r = $urandom_range(0, 7);
      drive(a_r[N-1:0], s_r, 2, model(a_r[N-1:0], s_r, 2));
    end
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 rdy_mode = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid", bus.out_valid, 1);
      check_eq("stall_data", bus.out_data, exp_q[0]);
      check_eq("stall_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1 rdy_mode = 0;
    drain();

    // Reset with three items in flight.
    for (int i = 0; i < 3; i++) drive(8'h5A, i, 1, model(8'h5A, i, 1));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_out_valid", bus.out_valid, 0);
    check_eq("mid_rst_out_data", bus.out_data, 0);
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    drive(8'hC3, 2, 2, 8'hF1);
    drain();
    lat_chk = 1'b0;

    // Exhaustive sweep under random output throttling.
    rdy_mode = 2;
    base_acc = acc_cnt;
    base_pop = pop_cnt;
    for (int m = 0; m < 3; m++)
      for (int s = 0; s < 8; s++)
        for (int a = 0; a < 256; a++)
          drive(a[N-1:0], s, m, model(a[N-1:0], s, m));
    rdy_mode = 0;
    drain();
    check_eq("sweep_accepts", acc_cnt - base_acc, 256 * 8 * 3);
    check_eq("sweep_results", pop_cnt - base_pop, acc_cnt - base_acc);
    check_eq("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
